// File: rtl/uart_tx_buffered.sv
// UART transmitter with a one-entry holding buffer.
// Frame: start bit, NB_DATA data bits LSB first, stop period of SB_TICK ticks.
// Bit timing is driven by an external oversampling tick (OVERSAMPLE ticks/bit).
// A byte arriving while a frame is in flight is parked in the holding buffer
// and sent back-to-back; a further byte while the buffer is full is dropped
// and flagged on the sticky overrun output.
module uart_tx_buffered #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tx_valid,
  output logic               o_tx,
  output logic               o_tx_ready,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic               o_overrun
);

  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shift_reg;
  logic [NB_DATA-1:0] buf_data;
  logic               buf_full;
  logic               tx_r;
  logic               done_r;
  logic               ovr_r;

  logic               stop_end;
  logic [NB_DATA-1:0] shift_nxt;

  // Last tick of the stop period: the edge where the buffer may be consumed.
  assign stop_end  = (state == STOP) && i_tick && (tick_cnt == SB_LAST);
  assign shift_nxt = shift_reg >> 1;

  // Frame sequencer, holding buffer and registered line/status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // Holding buffer. In IDLE, and at a stop end with the buffer empty, the
      // byte goes straight to the shift register instead (handled below).
      if (i_tx_valid && state != IDLE) begin
        if (stop_end) begin
          // Buffer is being consumed this edge: refill it, stays full.
          if (buf_full) buf_data <= i_tx_data;
        end else if (!buf_full) begin
          buf_data <= i_tx_data;
          buf_full <= 1'b1;
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (stop_end && buf_full) begin
        buf_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (i_tx_valid) begin
            // A tick on this edge is deliberately not counted.
            shift_reg <= i_tx_data;
            tick_cnt  <= '0;
            state     <= START;
            tx_r      <= 1'b0;
          end
        end
        START: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
              tx_r     <= shift_reg[0];
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= shift_nxt;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
                tx_r  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                tx_r    <= shift_nxt[0];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              done_r   <= 1'b1;
              if (buf_full) begin
                shift_reg <= buf_data;
                state     <= START;
                tx_r      <= 1'b0;
              end else if (i_tx_valid) begin
                shift_reg <= i_tx_data;
                state     <= START;
                tx_r      <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tx       = tx_r;
  assign o_tx_done  = done_r;
  assign o_overrun  = ovr_r;
  assign o_tx_ready = ~buf_full;
  assign o_tx_busy  = (state != IDLE);

endmodule
